// File: rtl/conv3x3_row_mac_pkg.sv
// Shared types and helpers for the 3x3 row convolution MAC.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv3x3_row_mac_pkg;

  localparam int INT_BITS_DEF = 13;
  localparam int W_BITS_DEF   = 8;
  localparam int N_LANES      = 9;
  localparam int N_TAPS       = 3;
  localparam logic [2:0] LAST_ROW = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Nine products of INT_BITS x W_BITS need at most 4 extra bits of growth.
  function automatic int acc_bits(input int int_bits, input int w_bits);
    return int_bits + w_bits + 4;
  endfunction

  // LSB of column col inside one lane word; column 0 (oldest) sits in the top slice.
  function automatic int tap_lsb(input int int_bits, input int col);
    return (N_TAPS - 1 - col) * int_bits;
  endfunction

endpackage

// File: rtl/conv_dot9.sv
// Nine-term signed dot product (pixels x weights) feeding a balanced adder tree.
// Latency: combinational.
// Backpressure: none; output follows inputs.
//   px  : 9 signed pixels, index k = 3*dr+dc
//   wt  : 9 signed weights, same indexing
//   acc : signed sum, full precision
module conv_dot9 #(
  parameter int INT_BITS = 13,
  parameter int W_BITS   = 8,
  parameter int ACC_BITS = 25
) (
  input  logic [8:0][INT_BITS-1:0] px,
  input  logic [8:0][W_BITS-1:0]   wt,
  output logic signed [ACC_BITS-1:0] acc
);

  logic signed [ACC_BITS-1:0] prod [9];
  logic signed [ACC_BITS-1:0] lvl1 [4];
  logic signed [ACC_BITS-1:0] lvl2 [2];

  // Operands are sign-extended to the result width first, so the truncated
  // product is exact (the true product always fits in ACC_BITS).
  for (genvar k = 0; k < 9; k++) begin : g_prod
    assign prod[k] = ACC_BITS'($signed(px[k])) * ACC_BITS'($signed(wt[k]));
  end

  for (genvar i = 0; i < 4; i++) begin : g_lvl1
    assign lvl1[i] = prod[2*i] + prod[2*i+1];
  end

  for (genvar j = 0; j < 2; j++) begin : g_lvl2
    assign lvl2[j] = lvl1[2*j] + lvl1[2*j+1];
  end

  assign acc = lvl2[0] + lvl2[1] + prod[8];

endmodule

// File: rtl/conv3x3_row_mac.sv
// 3x3 convolution over a 9-lane x 3-tap slab, emitting 7 output rows per slab.
// Latency: row 0 valid one cycle after slab acceptance, then one row per cycle; 8-cycle slab period.
// Backpressure: out_ready low holds all outputs stable and keeps win_ready low.
//   clk, reset(async active-low)
//   win/win_valid/win_ready/relu_en : slab input stream
//   w_we/w_addr/w_data              : shadow weight bank write port
//   out_data/out_row/out_last/out_valid/out_ready : result stream
//   busy                            : not idle
module conv3x3_row_mac
  import conv3x3_row_mac_pkg::*;
#(
  parameter int INT_BITS = INT_BITS_DEF,
  parameter int W_BITS   = W_BITS_DEF,
  localparam int ACC_BITS = acc_bits(INT_BITS, W_BITS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [8:0][3*INT_BITS-1:0]  win,
  input  logic                        win_valid,
  output logic                        win_ready,
  input  logic                        relu_en,
  input  logic                        w_we,
  input  logic [3:0]                  w_addr,
  input  logic [W_BITS-1:0]           w_data,
  output logic signed [ACC_BITS-1:0]  out_data,
  output logic [2:0]                  out_row,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
);

  state_t state, state_nxt;
  logic [2:0] row;
  logic       vld_q;
  logic [8:0][3*INT_BITS-1:0] win_q;
  logic       relu_q;
  logic [8:0][W_BITS-1:0] shadow;
  logic [8:0][W_BITS-1:0] active;
  logic       pending;
  logic       accept;
  logic       out_fire;
  logic [8:0][INT_BITS-1:0] px;
  logic signed [ACC_BITS-1:0] acc;

  assign out_valid = vld_q;
  assign out_row   = row;
  assign out_last  = vld_q & (row == LAST_ROW);
  assign busy      = (state != IDLE);
  assign win_ready = (state == IDLE) | (out_valid & out_last & out_ready);
  assign accept    = win_valid & win_ready;
  assign out_fire  = vld_q & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (out_fire && row == LAST_ROW) state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The cycle after acceptance is a bubble (vld_q still low) so row 0 is
  // presented one edge later; this bubble also appears on back-to-back slabs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row   <= '0;
      vld_q <= 1'b0;
    end else if (accept) begin
      row   <= '0;
      vld_q <= 1'b0;
    end else if (state == RUN) begin
      if (!vld_q) begin
        vld_q <= 1'b1;
      end else if (out_fire) begin
        if (row == LAST_ROW) vld_q <= 1'b0;
        else                 row   <= row + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q  <= '0;
      relu_q <= 1'b0;
    end else if (accept) begin
      win_q  <= win;
      relu_q <= relu_en;
    end
  end

  // Commit reads the pre-write shadow, so a write coinciding with acceptance
  // stays pending for the following slab.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (accept && pending) active <= shadow;
      if (w_we && w_addr <= 4'd8) begin
        shadow[w_addr] <= w_data;
        pending        <= 1'b1;
      end else if (accept) begin
        pending <= 1'b0;
      end
    end
  end

  // Row mux: output row r uses slab lanes r..r+2.
  for (genvar dr = 0; dr < 3; dr++) begin : g_dr
    for (genvar dc = 0; dc < 3; dc++) begin : g_dc
      assign px[3*dr+dc] = win_q[{1'b0, row} + 4'(dr)][tap_lsb(INT_BITS, dc) +: INT_BITS];
    end
  end

  conv_dot9 #(
    .INT_BITS (INT_BITS),
    .W_BITS   (W_BITS),
    .ACC_BITS (ACC_BITS)
  ) u_dot (
    .px  (px),
    .wt  (active),
    .acc (acc)
  );

  assign out_data = (relu_q && acc[ACC_BITS-1]) ? '0 : acc;

endmodule

// File: tb/tb_conv3x3_row_mac.sv
module tb_conv3x3_row_mac;

  localparam int IB = 13;
  localparam int WB = 8;
  localparam int AB = IB + WB + 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [8:0][3*IB-1:0]     win = '0;
  logic                     win_valid = 1'b0;
  logic                     win_ready;
  logic                     relu_en = 1'b0;
  logic                     w_we = 1'b0;
  logic [3:0]               w_addr = '0;
  logic [WB-1:0]            w_data = '0;
  logic signed [AB-1:0]     out_data;
  logic [2:0]               out_row;
  logic                     out_last;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic                     busy;

  conv3x3_row_mac dut (
    .clk(clk), .reset(reset), .win(win), .win_valid(win_valid), .win_ready(win_ready),
    .relu_en(relu_en), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out_data(out_data), .out_row(out_row), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit rdy_rand  = 1'b0;
  bit rdy_force = 1'b1;
  always @(posedge clk) begin
    #1;
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: weight banks and slab pixels as plain integers.
  typedef struct {
    longint data;
    int     row;
    bit     last;
  } exp_t;

  exp_t   sb[$];
  int     row0_cyc[$];
  longint m_sh[9];
  longint m_act[9];
  bit     m_pend;
  int     pix[9][3];
  int     acc_cyc;
  exp_t   e;

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        check("data", longint'(out_data), e.data);
        check("row", longint'(out_row), e.row);
        check("last", longint'(out_last), e.last);
        if (out_row == 3'd0) row0_cyc.push_back(cyc);
      end
    end
  end

  task automatic model_clear();
    for (int k = 0; k < 9; k++) begin
      m_sh[k]  = 0;
      m_act[k] = 0;
    end
    m_pend = 1'b0;
  endtask

  task automatic model_write(input int a, input int d);
    if (a <= 8) begin
      m_sh[a] = d;
      m_pend  = 1'b1;
    end
  endtask

  task automatic model_accept(input bit relu);
    longint s;
    exp_t x;
    if (m_pend) begin
      for (int k = 0; k < 9; k++) m_act[k] = m_sh[k];
      m_pend = 1'b0;
    end
    for (int r = 0; r < 7; r++) begin
      s = 0;
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          s += longint'(pix[r+dr][dc]) * m_act[3*dr+dc];
      if (relu && s < 0) s = 0;
      x.data = s;
      x.row  = r;
      x.last = (r == 6);
      sb.push_back(x);
    end
  endtask

  task automatic wr(input int a, input int d);
    w_we   = 1'b1;
    w_addr = 4'(a);
    w_data = WB'(d);
    @(posedge clk);
    model_write(a, d);
    #1;
    w_we = 1'b0;
  endtask

  task automatic send_slab(input bit relu, input bit do_wr, input int wa, input int wd);
    int n;
    for (int i = 0; i < 9; i++)
      win[i] = {IB'(pix[i][0]), IB'(pix[i][1]), IB'(pix[i][2])};
    relu_en   = relu;
    win_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!win_ready && n < 300);
    if (!win_ready) begin
      check("accept_timeout", 0, 1);
      win_valid = 1'b0;
      return;
    end
    if (do_wr) begin
      w_we   = 1'b1;
      w_addr = 4'(wa);
      w_data = WB'(wd);
    end
    @(posedge clk);
    model_accept(relu);
    if (do_wr) model_write(wa, wd);
    #1;
    acc_cyc   = cyc;
    win_valid = 1'b0;
    w_we      = 1'b0;
    relu_en   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_row(input int r);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_row == 3'(r)) && n < 100);
    check("wait_row", longint'(out_valid && out_row == 3'(r)), 1);
  endtask

  task automatic set_identity_pix();
    for (int i = 0; i < 9; i++)
      for (int c = 0; c < 3; c++) pix[i][c] = i + 1;
  endtask

  initial begin
    int lat;
    int gap;
    int nw;
    model_clear();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_busy", busy, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_row", out_row, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_win_ready", win_ready, 1);

    // Identity kernel and first-row latency
    wr(4, 1);
    set_identity_pix();
    row0_cyc.delete();
    send_slab(1'b0, 1'b0, 0, 0);
    lat = acc_cyc;
    drain();
    lat = (row0_cyc.size() > 0) ? row0_cyc[0] - lat : -1;
    check("first_row_latency", lat, 1);

    // Backpressure at row 2
    send_slab(1'b0, 1'b0, 0, 0);
    wait_row(1);
    rdy_force = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_row", out_row, 2);
      check("bp_data", longint'(out_data), 4);
      check("bp_valid", out_valid, 1);
      check("bp_win_ready", win_ready, 0);
    end
    rdy_force = 1'b1;
    drain();

    // Mid-slab weight write only affects the next slab
    send_slab(1'b0, 1'b0, 0, 0);
    wait_row(2);
    wr(4, 2);
    drain();
    send_slab(1'b0, 1'b0, 0, 0);
    drain();

    // Extremes and ReLU
    for (int k = 0; k < 9; k++) wr(k, 1);
    for (int i = 0; i < 9; i++)
      for (int c = 0; c < 3; c++) pix[i][c] = -4096;
    send_slab(1'b0, 1'b0, 0, 0);
    drain();
    send_slab(1'b1, 1'b0, 0, 0);
    drain();

    // Back-to-back slabs: 8-cycle period with one bubble
    set_identity_pix();
    row0_cyc.delete();
    send_slab(1'b0, 1'b0, 0, 0);
    send_slab(1'b0, 1'b0, 0, 0);
    check("bubble_valid", out_valid, 0);
    check("bubble_busy", busy, 1);
    drain();
    gap = (row0_cyc.size() >= 2) ? row0_cyc[1] - row0_cyc[0] : -1;
    check("slab_period", gap, 8);

    // Reset mid-slab
    send_slab(1'b0, 1'b0, 0, 0);
    wait_row(3);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    model_clear();
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_win_ready", win_ready, 1);
    wr(9, 5);
    send_slab(1'b0, 1'b0, 0, 0);
    drain();

    // Randomized traffic with random backpressure and weight updates
    rdy_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 9; i++)
        for (int c = 0; c < 3; c++) pix[i][c] = int'($urandom_range(0, 8191)) - 4096;
      nw = $urandom_range(0, 3);
      for (int j = 0; j < nw; j++)
        wr($urandom_range(0, 15), int'($urandom_range(0, 255)) - 128);
      send_slab(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 9), int'($urandom_range(0, 255)) - 128);
    end
    rdy_rand  = 1'b0;
    rdy_force = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/conv3x3_row_mac.md
# conv3x3_row_mac

Downstream consumer of the line buffer: accepts one 9-lane × 3-tap window slab per handshake and computes the 7 valid 3×3 convolution outputs down the slab. Results are emitted one row per cycle on a valid/ready stream. Weights are loaded through a shadow bank so that a load never corrupts a slab in flight. The block sits between the line buffer and the activation/requantisation stage.

## Interface
- INT_BITS, 13, signed pixel width (matches the line buffer)
- W_BITS, 8, signed weight width
- ACC_BITS, INT_BITS+W_BITS+4 (derived localparam, not overridable), signed result width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- win  in  [3*INT_BITS-1:0] x [8:0]  slab, lane i = row i; bits [3*INT_BITS-1:2*INT_BITS] = column 0 (oldest), [INT_BITS-1:0] = column 2 (newest)
- win_valid  in  1  slab present
- win_ready  out  1  slab accepted when win_valid & win_ready
- relu_en  in  1  sampled at slab acceptance
- w_we  in  1  weight write strobe
- w_addr  in  4  weight index k = 3*dr+dc; values 9..15 ignored
- w_data  in  W_BITS  signed weight
- out_data  out  ACC_BITS  signed result
- out_row  out  3  output row 0..6
- out_last  out  1  high with row 6
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts
- busy  out  1  state != IDLE

## Operation
- FSM: IDLE, RUN. In IDLE, win_ready=1; out_valid=0.
- Accept (IDLE, win_valid): latch slab and relu_en; if weight_pending, copy shadow→active and clear pending; row:=0; go RUN.
- RUN: result(r) = Σ_{dr,dc} win[r+dr][col dc] * active[3*dr+dc], full signed precision; if latched relu then max(0, ·). Cannot overflow ACC_BITS.
- Each out handshake advances row; the handshake at row 6 returns to IDLE.
- win_ready = IDLE | (out_valid & out_last & out_ready); an acceptance on that cycle restarts RUN directly.
- Weight write: w_we with w_addr<=8 writes shadow[w_addr] and sets pending, in any state. A write in the same cycle as an acceptance lands in shadow after the commit and stays pending for the next slab.
- Reset: state IDLE, row 0, all outputs 0 except win_ready=1 after release; shadow, active, and pending cleared to 0.

## Timing
- Slab accepted at edge k → out_valid=1 with row 0 after edge k+1.
- With out_ready held high: rows 0..6 on consecutive cycles; next slab accepted on row 6's handshake edge, row 0 of that slab after the following edge. Sustained period is 8 cycles per slab, with one bubble cycle of out_valid=0.
- out_ready low: out_data, out_row, out_last, and out_valid stay stable; win_ready stays low.
- Weight commit latency: effective from the first slab accepted after the write edge.
- Reset assertion takes effect immediately, mid-slab included; the partial slab is discarded.

## Structure
- Shared package: INT_BITS/W_BITS defaults, ACC_BITS derivation function, FSM state enum, tap-slice helper (lane, column).
- Sub-module conv_dot9: combinational 9-term signed multiply plus adder tree (INT_BITS × W_BITS → ACC_BITS). It is instantiated once and fed from the latched slab rows r..r+2 via a row mux.

## Test plan
- Reset: hold reset=0 → out_valid=0, out_data=0, busy=0; after release win_ready=1.
- Identity kernel: w[4]=1, others 0; lane i all taps = i+1, relu off → rows 0..6 give 2,3,4,5,6,7,8 on consecutive cycles, out_last only on row 6.
- Extremes and ReLU: all weights 1, all taps −4096. relu off → each row −36864; relu on → each row 0.
- Backpressure: out_ready=0 for 3 cycles at row 2 → out_row=2 and out_data stable, win_ready=0, no row skipped or duplicated.
- Mid-slab weight write: during RUN write w[4]=2 → current slab still uses 1 (row values 2..8); next slab gives 4..16.
- Back-to-back and reset: two slabs with out_ready=1 → 8-cycle spacing with one bubble. Then assert reset at row 3 → out_valid=0 immediately; after release, all weights read 0 (identity-slab outputs 0).
